// File: rtl/rsa_pkg.sv
// Shared constants and FSM state encoding for the RSA result write-back path.
package rsa_pkg;

  localparam int RSA_WIDTH  = 1024;
  localparam int WORD_WIDTH = 32;
  localparam int RSA_WORDS  = 32;

  typedef logic [1:0] rsa_state_t;

  localparam rsa_state_t ST_IDLE  = 2'd0;
  localparam rsa_state_t ST_LOAD  = 2'd1;
  localparam rsa_state_t ST_WRITE = 2'd2;
  localparam rsa_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rsa_result_writer.sv
// Streams a latched 1024-bit RSA result out as NUM_WORDS consecutive Avalon-MM
// word writes, then raises a sticky done flag and a level interrupt.
module rsa_result_writer
  import rsa_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                 iSys_clk,
  input  logic                 iRstn,
  input  logic                 iClear,
  input  logic                 iStart,
  input  logic [31:0]          iBase_Address,
  input  logic [RSA_WIDTH-1:0] iResult,
  input  logic                 iIrq_Ack,
  input  logic                 iWaitRequest,
  output logic [31:0]          oAddress,
  output logic [31:0]          oWriteData,
  output logic                 oWrite,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oIrq,
  output logic [31:0]          oCycles,
  output rsa_state_t           oState
);

  localparam int               CNT_W     = 6;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  rsa_state_t           state;
  logic [RSA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]     word_cnt;
  logic                 accept;
  logic                 last_word;

  // Avalon-MM write handshake: a word is transferred on a rising edge where
  // oWrite=1 and iWaitRequest=0; while iWaitRequest=1 the master holds
  // oWrite, oAddress and oWriteData unchanged.
  assign accept    = (state == ST_WRITE) && !iWaitRequest;
  assign last_word = (word_cnt == LAST_WORD);
  assign oBusy     = (state == ST_LOAD) || (state == ST_WRITE);
  assign oState    = state;

  always_ff @(posedge iSys_clk or negedge iRstn) begin
    if (!iRstn) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      word_cnt   <= '0;
      oAddress   <= '0;
      oWriteData <= '0;
      oWrite     <= 1'b0;
      oDone      <= 1'b0;
      oIrq       <= 1'b0;
      oCycles    <= '0;
    end else if (iClear) begin
      // Abandons any in-flight write, even one stalled by wait request.
      state    <= ST_IDLE;
      oWrite   <= 1'b0;
      oDone    <= 1'b0;
      oIrq     <= 1'b0;
      oCycles  <= '0;
      word_cnt <= '0;
    end else begin
      if (accept && last_word) begin
        oIrq <= 1'b1;
      end else if (iIrq_Ack) begin
        oIrq <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state    <= ST_LOAD;
            shift_q  <= iResult;
            oAddress <= iBase_Address;
            word_cnt <= '0;
            oCycles  <= '0;
            oDone    <= 1'b0;
          end
        end
        ST_LOAD: begin
          state      <= ST_WRITE;
          oWriteData <= shift_q[WORD_WIDTH-1:0];
          oWrite     <= 1'b1;
        end
        ST_WRITE: begin
          oCycles <= oCycles + 32'd1;
          if (!iWaitRequest) begin
            if (last_word) begin
              state  <= ST_DONE;
              oWrite <= 1'b0;
              oDone  <= 1'b1;
            end else begin
              // Next word is presented on the same edge the current one is taken.
              shift_q    <= shift_q >> WORD_WIDTH;
              oWriteData <= shift_q[2*WORD_WIDTH-1:WORD_WIDTH];
              oAddress   <= oAddress + 32'(ADDR_STRIDE);
              word_cnt   <= word_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!iStart) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_result_writer.sv
// Bench for rsa_result_writer: table of jobs against a queue-based reference
// model, plus hand-written sequences for clear, held start, wrap and reset.
module tb_rsa_result_writer;
  import rsa_pkg::*;

  logic            clk   = 1'b0;
  logic            rstn  = 1'b1;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic            ack   = 1'b0;
  logic            wreq  = 1'b0;
  logic [31:0]     base  = '0;
  logic [1023:0]   result = '0;
  logic [31:0]     addr, wdata, cycles;
  logic            wr, busy, done, irq;
  rsa_state_t      st;

  logic            start4 = 1'b0;
  logic            wreq4  = 1'b0;
  logic [31:0]     base4  = '0;
  logic [31:0]     addr4, wdata4, cycles4;
  logic            wr4, busy4, done4, irq4;
  rsa_state_t      st4;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  typedef struct {
    logic [31:0] base;
    bit          incr_data;
    int          wait_pct;
    bit          ack_at_done;
    logic [31:0] exp_last;
  } job_vec_t;

  rsa_result_writer dut (
    .iSys_clk(clk), .iRstn(rstn), .iClear(clear), .iStart(start),
    .iBase_Address(base), .iResult(result), .iIrq_Ack(ack), .iWaitRequest(wreq),
    .oAddress(addr), .oWriteData(wdata), .oWrite(wr), .oBusy(busy),
    .oDone(done), .oIrq(irq), .oCycles(cycles), .oState(st)
  );

  rsa_result_writer #(.NUM_WORDS(4), .ADDR_STRIDE(4)) dut4 (
    .iSys_clk(clk), .iRstn(rstn), .iClear(clear), .iStart(start4),
    .iBase_Address(base4), .iResult(result), .iIrq_Ack(ack), .iWaitRequest(wreq4),
    .oAddress(addr4), .oWriteData(wdata4), .oWrite(wr4), .oBusy(busy4),
    .oDone(done4), .oIrq(irq4), .oCycles(cycles4), .oState(st4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] rand_1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [1023:0] incr_1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = 32'(i + 1);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  addr, 32'd0);
    check({tag, "_data"},  wdata, 32'd0);
    check({tag, "_write"}, 32'(wr), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_irq"},   32'(irq), 32'd0);
    check({tag, "_cyc"},   cycles, 32'd0);
    check({tag, "_state"}, 32'(st), 32'(ST_IDLE));
  endtask

  // Reference: word k goes to base + 4k (mod 2^32) carrying result bits [32k+31:32k];
  // cycles in WRITE = 32 accepted words + every stalled cycle.
  task automatic run_job(input logic [31:0] b, input logic [1023:0] res, input int wait_pct,
                         input bit hold_start, input bit ack_at_done,
                         output logic [31:0] last_addr);
    int          waits;
    int          budget;
    bit          fin;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    waits = 0; budget = 0; fin = 0; prev_wait = 0;
    prev_addr = '0; prev_data = '0; last_addr = '0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < 32; k++) begin
      exp_addr_q.push_back(b + 32'(4 * k));
      exp_data_q.push_back(res[32*k +: 32]);
    end
    cycle();
    start = 1'b1; base = b; result = res; wreq = 1'b0;
    cycle();
    start = hold_start;
    result = rand_1024();
    check("load_write", 32'(wr), 32'd0);
    check("load_state", 32'(st), 32'(ST_LOAD));
    cycle();
    while (!fin && budget < 4000) begin
      budget++;
      check("write_strobe", 32'(wr), 32'd1);
      if (wr !== 1'b1) break;
      if (prev_wait) begin
        check("hold_addr", addr, prev_addr);
        check("hold_data", wdata, prev_data);
      end
      wreq = (int'($urandom_range(99)) < wait_pct);
      if (!wreq) begin
        check("word_addr", addr, exp_addr_q.pop_front());
        check("word_data", wdata, exp_data_q.pop_front());
        last_addr = addr;
        if (exp_addr_q.size() == 0) begin
          fin = 1;
          ack = ack_at_done;
        end
      end else begin
        waits++;
      end
      prev_wait = wreq; prev_addr = addr; prev_data = wdata;
      result = rand_1024();
      cycle();
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL job_timeout: %0d words outstanding, expected 0", exp_addr_q.size());
    end
    ack = 1'b0; wreq = 1'b0;
    check("done_write", 32'(wr), 32'd0);
    check("done_flag",  32'(done), 32'd1);
    check("done_irq",   32'(irq), 32'd1);
    check("done_busy",  32'(busy), 32'd0);
    check("done_state", 32'(st), 32'(ST_DONE));
    check("done_cycles", cycles, 32'(32 + waits));
  endtask

  initial begin
    job_vec_t      vecs[4];
    logic [31:0]   la;
    logic [31:0]   exp4[4];
    logic [1023:0] res4;

    vecs[0] = '{base: 32'h0000_1000, incr_data: 1'b1, wait_pct: 0,  ack_at_done: 1'b0, exp_last: 32'h0000_107C};
    vecs[1] = '{base: 32'h0000_1000, incr_data: 1'b1, wait_pct: 50, ack_at_done: 1'b0, exp_last: 32'h0000_107C};
    vecs[2] = '{base: 32'hFFFF_FFC0, incr_data: 1'b0, wait_pct: 50, ack_at_done: 1'b1, exp_last: 32'h0000_003C};
    vecs[3] = '{base: 32'h8000_0000, incr_data: 1'b0, wait_pct: 25, ack_at_done: 1'b0, exp_last: 32'h8000_007C};
    exp4[0] = 32'hFFFF_FFF8; exp4[1] = 32'hFFFF_FFFC; exp4[2] = 32'h0000_0000; exp4[3] = 32'h0000_0004;

    #2 rstn = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].base, vecs[i].incr_data ? incr_1024() : rand_1024(),
              vecs[i].wait_pct, 1'b0, vecs[i].ack_at_done, la);
      check("last_addr", la, vecs[i].exp_last);
      if (i == 0) begin
        cycle();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        check("ack_irq", 32'(irq), 32'd0);
        check("idle_done_sticky", 32'(done), 32'd1);
        check("idle_state", 32'(st), 32'(ST_IDLE));
      end
    end

    // NUM_WORDS=4 instance wrapping past the top of the address space.
    res4 = rand_1024();
    result = res4;
    cycle();
    start4 = 1'b1; base4 = 32'hFFFF_FFF8;
    cycle();
    start4 = 1'b0;
    check("w4_load_state", 32'(st4), 32'(ST_LOAD));
    cycle();
    for (int k = 0; k < 4; k++) begin
      check("w4_write", 32'(wr4), 32'd1);
      check("w4_addr", addr4, exp4[k]);
      check("w4_data", wdata4, res4[32*k +: 32]);
      cycle();
    end
    check("w4_done_write", 32'(wr4), 32'd0);
    check("w4_done", 32'(done4), 32'd1);
    check("w4_irq", 32'(irq4), 32'd1);
    check("w4_cycles", cycles4, 32'd4);

    // Clear while word 10 is stalled.
    cycle();
    start = 1'b1; base = 32'h0000_2000; result = rand_1024(); wreq = 1'b0;
    cycle();
    start = 1'b0;
    cycle();
    for (int k = 0; k < 10; k++) cycle();
    check("clr_word10_addr", addr, 32'h0000_2028);
    wreq = 1'b1;
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0; wreq = 1'b0;
    check("clr_write", 32'(wr), 32'd0);
    check("clr_state", 32'(st), 32'(ST_IDLE));
    check("clr_done", 32'(done), 32'd0);
    check("clr_irq", 32'(irq), 32'd0);
    check("clr_cycles", cycles, 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    run_job(32'h0000_3000, rand_1024(), 30, 1'b0, 1'b0, la);
    check("clr_rerun_last", la, 32'h0000_307C);

    // Start held through completion: exactly one job, then ack.
    run_job(32'h0000_4000, rand_1024(), 20, 1'b1, 1'b0, la);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("hold_state", 32'(st), 32'(ST_DONE));
      check("hold_write", 32'(wr), 32'd0);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    check("hold_ack_irq", 32'(irq), 32'd0);
    check("hold_done", 32'(done), 32'd1);
    start = 1'b0;
    cycle();
    check("hold_release_state", 32'(st), 32'(ST_IDLE));
    run_job(32'h0000_5000, incr_1024(), 0, 1'b0, 1'b0, la);
    check("hold_second_last", la, 32'h0000_507C);

    // Asynchronous reset mid-job, checked between clock edges.
    cycle();
    start = 1'b1; base = 32'h0000_6000; result = rand_1024();
    cycle();
    start = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    check("pre_rst_write", 32'(wr), 32'd1);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
